// File: rtl/arith_logic_unit.sv
// arith_logic_unit
//   Execution unit fed by the reservation station. Issued instructions are
//   queued in a small in-order FIFO. The FIFO head is evaluated
//   combinationally, and the result is registered onto the common data bus
//   (CDB) at the next edge.
//
// Ports
//   clk_in       system clock
//   rst_in       synchronous active-high reset
//   rdy_in       ready; when low, the queue is not popped and the CDB holds
//   _clear       synchronous pipeline flush (misprediction)
//   _alu_ready   issue valid from the reservation station
//   _alu_rob_id  ROB tag of the issued instruction
//   _alu_type    instruction class (0 arith, 1 branch, other: v1 + v2)
//   _alu_op      operation within the class
//   _alu_v1      operand 1
//   _alu_v2      operand 2 (register or immediate, selected upstream)
//   _alu_full    high when an issue is not accepted this cycle
//   _cdb_ready   CDB result valid (one cycle per result)
//   _cdb_rob_id  ROB tag of the broadcast result
//   _cdb_value   broadcast result value
module arith_logic_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alu_ready,
  input  logic [4:0]  _alu_rob_id,
  input  logic [4:0]  _alu_type,
  input  logic [3:0]  _alu_op,
  input  logic [31:0] _alu_v1,
  input  logic [31:0] _alu_v2,
  output logic        _alu_full,
  output logic        _cdb_ready,
  output logic [4:0]  _cdb_rob_id,
  output logic [31:0] _cdb_value
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  rob_id;
    logic [4:0]  kind;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
  } entry_t;

  entry_t        queue [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic   push;
  logic   pop;
  entry_t head_entry;
  logic [31:0] result;

  // Full ignores a same-cycle pop, so the issuer sees a purely registered
  // view of occupancy.
  assign _alu_full = (count == FULL_COUNT);

  // The issue side keeps accepting entries while the unit is stalled. This
  // lets the queue absorb a backlog and is the only way it can fill, because
  // an active unit drains one entry every cycle.
  assign push = _alu_ready && !_alu_full;
  assign pop  = rdy_in && (count != '0);

  assign head_entry = queue[head];

  // Queue storage.
  // NOTE: the storage array has no reset. Validity is tracked entirely by
  // head/tail/count, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !_clear && push) begin
      queue[tail] <= '{rob_id: _alu_rob_id, kind: _alu_type, op: _alu_op,
                       v1: _alu_v1, v2: _alu_v2};
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignments only, so every
  // always_ff sees the pre-edge values of the other registers.
  always_ff @(posedge clk_in) begin
    if (rst_in || _clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Evaluate the head entry.
  // NOTE: every branch of this block is covered by the default assigned
  // first, so no latch can be inferred.
  always_comb begin
    logic [4:0] shamt;
    result = '0;
    shamt  = head_entry.v2[4:0];
    unique case (head_entry.kind)
      5'd0: begin
        case (head_entry.op)
          4'd0:    result = head_entry.v1 + head_entry.v2;
          4'd1:    result = head_entry.v1 - head_entry.v2;
          4'd2:    result = head_entry.v1 << shamt;
          4'd3:    result = {31'd0, $signed(head_entry.v1) < $signed(head_entry.v2)};
          4'd4:    result = {31'd0, head_entry.v1 < head_entry.v2};
          4'd5:    result = head_entry.v1 ^ head_entry.v2;
          4'd6:    result = head_entry.v1 >> shamt;
          4'd7:    result = $unsigned($signed(head_entry.v1) >>> shamt);
          4'd8:    result = head_entry.v1 | head_entry.v2;
          4'd9:    result = head_entry.v1 & head_entry.v2;
          default: result = '0;
        endcase
      end
      5'd1: begin
        case (head_entry.op)
          4'd0:    result = {31'd0, head_entry.v1 == head_entry.v2};
          4'd1:    result = {31'd0, head_entry.v1 != head_entry.v2};
          4'd2:    result = {31'd0, $signed(head_entry.v1) <  $signed(head_entry.v2)};
          4'd3:    result = {31'd0, $signed(head_entry.v1) >= $signed(head_entry.v2)};
          4'd4:    result = {31'd0, head_entry.v1 <  head_entry.v2};
          4'd5:    result = {31'd0, head_entry.v1 >= head_entry.v2};
          default: result = '0;
        endcase
      end
      // Address generation, LUI and AUIPC all reduce to a plain add.
      default: result = head_entry.v1 + head_entry.v2;
    endcase
  end

  // CDB output stage. A flush kills the head being evaluated. A stall freezes
  // the broadcast exactly as it stands.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      _cdb_ready  <= 1'b0;
      _cdb_rob_id <= '0;
      _cdb_value  <= '0;
    end else if (_clear) begin
      _cdb_ready  <= 1'b0;
    end else if (rdy_in) begin
      _cdb_ready <= pop;
      if (pop) begin
        _cdb_rob_id <= head_entry.rob_id;
        _cdb_value  <= result;
      end
    end
  end

endmodule
